// File: rtl/nonogram_pkg.sv
// Shared definitions for the nonogram solver output path: grid size defaults,
// frame marker, payload mode, serializer state and frame field encodings.
package nonogram_pkg;

  localparam int         DEF_MAX_DIM  = 11;
  localparam int         DEF_DIM_W    = 4;
  localparam logic [7:0] DEF_SOF_BYTE = 8'hA5;

  typedef enum logic {
    MODE_CELL   = 1'b0,
    MODE_PACKED = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    F_SOF,
    F_M,
    F_N,
    F_MODE,
    F_PAY,
    F_CSUM
  } field_e;

  function automatic int unsigned packed_bytes_per_row(input int unsigned n);
    return (n + 7) / 8;
  endfunction

endpackage

// File: rtl/grid_byte_picker.sv
// Combinational payload byte selector: one cell per byte, or an LSB-first
// bitmap slice of a row with columns at or beyond n forced to zero.
module grid_byte_picker
  import nonogram_pkg::*;
#(
  parameter int MAX_DIM = DEF_MAX_DIM,
  parameter int DIM_W   = DEF_DIM_W
) (
  input  logic [MAX_DIM*MAX_DIM-1:0] grid,
  input  mode_e                      mode,
  input  logic [DIM_W-1:0]           row,
  input  logic [DIM_W-1:0]           col,
  input  logic [DIM_W-1:0]           n,
  output logic [7:0]                 pay_byte
);

  logic [MAX_DIM-1:0]   row_bits;
  logic [MAX_DIM-1:0]   col_mask;
  logic [MAX_DIM-1:0]   cell_sh;
  logic [MAX_DIM+7:0]   row_pad;
  logic [MAX_DIM+7:0]   pad_sh;

  always_comb begin
    row_bits = MAX_DIM'(grid >> (int'(row) * MAX_DIM));
    for (int c = 0; c < MAX_DIM; c++) begin
      col_mask[c] = (c < int'(n));
    end
    // Eight zero bits on top so the last partial byte of a row pads with 0.
    row_pad  = {8'b0, row_bits & col_mask};
    pad_sh   = row_pad >> {col, 3'b000};
    cell_sh  = row_bits >> col;
    if (mode == MODE_PACKED) begin
      pay_byte = pad_sh[7:0];
    end else begin
      pay_byte = {7'b0, cell_sh[0]};
    end
  end

endmodule

// File: rtl/grid_frame_serializer.sv
// Latches a solved grid and streams SOF / m / n / mode / payload / XOR checksum
// to the UART transmitter, one byte per tx_done handshake.
module grid_frame_serializer
  import nonogram_pkg::*;
#(
  parameter int         MAX_DIM  = DEF_MAX_DIM,
  parameter int         DIM_W    = DEF_DIM_W,
  parameter logic [7:0] SOF_BYTE = DEF_SOF_BYTE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [MAX_DIM*MAX_DIM-1:0] solution,
  input  logic [DIM_W-1:0]           m,
  input  logic [DIM_W-1:0]           n,
  input  logic                       mode,
  input  logic                       tx_done,
  output logic                       send,
  output logic [7:0]                 byte_out,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int               CELLS   = MAX_DIM * MAX_DIM;
  localparam logic [DIM_W-1:0] DIM_LIM = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE     = DIM_W'(1);

  logic [1:0]       rst_sync;
  logic             rst_sync_n;
  state_e           state;
  field_e           field, nxt_field;
  logic [CELLS-1:0] grid_q;
  logic [DIM_W-1:0] m_q, n_q, row, col, nxt_row, nxt_col, last_col;
  mode_e            mode_q;
  logic [7:0]       csum, pay_byte, nxt_byte;
  logic             more, req_ok;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_sync_n = rst_sync[1];

  assign req_ok = (m != '0) && (n != '0) && (m <= DIM_LIM) && (n <= DIM_LIM);

  // Byte pointer advance: header fields, then row-major payload, then checksum.
  always_comb begin
    nxt_field = field;
    nxt_row   = row;
    nxt_col   = col;
    more      = 1'b1;
    last_col  = (mode_q == MODE_PACKED) ?
                DIM_W'(packed_bytes_per_row(32'(n_q)) - 1) : n_q - ONE;
    case (field)
      F_SOF:  nxt_field = F_M;
      F_M:    nxt_field = F_N;
      F_N:    nxt_field = F_MODE;
      F_MODE: begin
        nxt_field = F_PAY;
        nxt_row   = '0;
        nxt_col   = '0;
      end
      F_PAY: begin
        if (col != last_col) begin
          nxt_col = col + ONE;
        end else begin
          nxt_col = '0;
          if (row != m_q - ONE) nxt_row = row + ONE;
          else                  nxt_field = F_CSUM;
        end
      end
      default: more = 1'b0;
    endcase

    nxt_byte = csum;
    case (nxt_field)
      F_SOF:   nxt_byte = SOF_BYTE;
      F_M:     nxt_byte = 8'(m_q);
      F_N:     nxt_byte = 8'(n_q);
      F_MODE:  nxt_byte = 8'(mode_q);
      F_PAY:   nxt_byte = pay_byte;
      default: nxt_byte = csum;
    endcase
  end

  grid_byte_picker #(
    .MAX_DIM (MAX_DIM),
    .DIM_W   (DIM_W)
  ) u_picker (
    .grid     (grid_q),
    .mode     (mode_q),
    .row      (nxt_row),
    .col      (nxt_col),
    .n        (n_q),
    .pay_byte (pay_byte)
  );

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state    <= ST_IDLE;
      field    <= F_SOF;
      grid_q   <= '0;
      m_q      <= '0;
      n_q      <= '0;
      mode_q   <= MODE_CELL;
      row      <= '0;
      col      <= '0;
      csum     <= '0;
      send     <= 1'b0;
      byte_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      send  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_in) begin
            if (!req_ok) begin
              error <= 1'b1;
            end else begin
              grid_q   <= solution;
              m_q      <= m;
              n_q      <= n;
              mode_q   <= mode_e'(mode);
              field    <= F_SOF;
              row      <= '0;
              col      <= '0;
              csum     <= '0;
              byte_out <= SOF_BYTE;
              send     <= 1'b1;
              busy     <= 1'b1;
              state    <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          csum  <= csum ^ byte_out;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (more) begin
              field    <= nxt_field;
              row      <= nxt_row;
              col      <= nxt_col;
              byte_out <= nxt_byte;
              send     <= 1'b1;
              state    <= ST_EMIT;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_frame_serializer.sv
// Randomized bench for grid_frame_serializer: a transmitter model acknowledges
// sends with random delays and holds, and frames are predicted from the format rules.
module tb_grid_frame_serializer;

  localparam int MD    = 11;
  localparam int CELLS = MD * MD;
  localparam int NREQ  = 37;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             valid_in = 1'b0;
  logic [CELLS-1:0] solution = '0;
  logic [3:0]       m = '0;
  logic [3:0]       n = '0;
  logic             mode = 1'b0;
  logic             tx_done = 1'b0;
  logic             send, busy, done, error;
  logic [7:0]       byte_out;

  grid_frame_serializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .solution (solution),
    .m        (m),
    .n        (n),
    .mode     (mode),
    .tx_done  (tx_done),
    .send     (send),
    .byte_out (byte_out),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cycles = 0;
  int         req_i = 0;
  int         gap = 0;
  int         idx = 0;
  int         delay = 0;
  int         hold = 0;
  bit         owed = 0;
  bit         rst_frame = 0;
  bit         e_send = 0, e_done = 0, e_error = 0, e_busy = 0;
  logic [7:0] last_byte = '0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, req, $time);
    end
  endtask

  // Expected frame built straight from the format rules.
  function automatic void build_frame(input logic [CELLS-1:0] g, input int rm, input int rn,
                                      input bit md);
    logic [7:0] b;
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(rm));
    exp_q.push_back(8'(rn));
    exp_q.push_back({7'b0, md});
    for (int r = 0; r < rm; r++) begin
      if (!md) begin
        for (int c = 0; c < rn; c++) exp_q.push_back({7'b0, g[r*MD+c]});
      end else begin
        for (int bi = 0; bi < (rn + 7) / 8; bi++) begin
          b = '0;
          for (int k = 0; k < 8; k++)
            if (bi * 8 + k < rn) b[k] = g[r*MD+bi*8+k];
          exp_q.push_back(b);
        end
      end
    end
    x = '0;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
  endfunction

  task automatic make_req(input int i, output int rm, output int rn, output bit rmd,
                          output logic [CELLS-1:0] rs, output bit rr);
    rs  = CELLS'({$urandom, $urandom, $urandom, $urandom});
    rmd = 1'($urandom);
    rr  = 1'b0;
    rm  = ($urandom_range(9) == 0) ? int'($urandom_range(15)) : int'($urandom_range(11, 1));
    rn  = ($urandom_range(9) == 0) ? int'($urandom_range(15)) : int'($urandom_range(11, 1));
    case (i)
      0, 1: begin rm = 2; rn = 3; rmd = (i == 1); rs = '0; rs[2:0] = 3'b111; end
      2, 3: begin rm = 11; rn = 11; rmd = (i == 2); rs = '1; end
      4:    begin rm = 0; rn = 3; end
      5:    begin rm = 2; rn = 12; end
      6:    begin rm = 2; rn = 3; rmd = 1'b0; rr = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    tx_done  = 1'b0;
    valid_in = 1'b0;
    #1;
    check("rst_send", send, 0);
    check("rst_byte", byte_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    owed = 0; hold = 0; delay = 0; idx = 0; rst_frame = 0;
    e_send = 0; e_done = 0; e_error = 0; e_busy = 0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      cycles++;
      check("rst_hold_done", done, 0);
      check("rst_hold_send", send, 0);
    end
    rst_n = 1'b1;
    gap   = 4;
  endtask

  task automatic step();
    bit               s_now, d_now, b_now, tx, rmd, rr;
    int               rm, rn;
    logic [CELLS-1:0] rs;
    @(negedge clk);
    cycles++;
    s_now = e_send;
    d_now = e_done;
    b_now = e_busy;
    check("busy", busy, b_now);
    check("send", send, s_now);
    check("done", done, d_now);
    check("error", error, e_error);
    if (s_now) begin
      check($sformatf("byte[%0d]", idx), byte_out, exp_q[idx]);
      last_byte = exp_q[idx];
      idx++;
    end else if (owed) begin
      check("byte_stable", byte_out, last_byte);
    end
    if (rst_frame && owed && idx == 5) begin
      do_reset();
      return;
    end

    e_send = 0; e_done = 0; e_error = 0;
    if (d_now) e_busy = 0;

    // Transmitter side: ack after a random delay, sometimes holding tx_done for 5 cycles.
    if (hold > 0) begin
      tx = 1'b1;
      hold--;
    end else if (owed && delay == 0) begin
      tx   = 1'b1;
      hold = ($urandom_range(3) == 0) ? 4 : 0;
    end else begin
      tx = !owed && ($urandom_range(7) == 0);
      if (owed) delay--;
    end
    tx_done = tx;
    if (tx && owed) begin
      owed = 0;
      if (idx < exp_q.size()) e_send = 1;
      else                    e_done = 1;
    end
    if (s_now) begin
      owed  = 1;
      delay = $urandom_range(2);
    end

    valid_in = 1'b0;
    if (!b_now) begin
      if (gap > 0) begin
        gap--;
      end else if (req_i < NREQ) begin
        make_req(req_i, rm, rn, rmd, rs, rr);
        req_i++;
        m = 4'(rm); n = 4'(rn); mode = rmd; solution = rs; valid_in = 1'b1;
        if (rm >= 1 && rm <= MD && rn >= 1 && rn <= MD) begin
          build_frame(rs, rm, rn, rmd);
          idx = 0; e_send = 1; e_busy = 1; rst_frame = rr;
        end else begin
          e_error = 1;
        end
        gap = $urandom_range(3);
      end
    end else if ($urandom_range(3) == 0) begin
      // Inputs wander while busy; occasionally with a stray valid_in.
      valid_in = ($urandom_range(3) == 0);
      m        = 4'($urandom);
      n        = 4'($urandom);
      mode     = 1'($urandom);
      solution = CELLS'({$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("init_send", send, 0);
    check("init_byte", byte_out, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_error", error, 0);
    rst_n = 1'b1;
    gap   = 4;
    while ((req_i < NREQ || e_busy) && cycles < 80000) step();
    if (cycles >= 80000) check("timeout", 1, 0);
    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
